// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall vectors, exception
// codes and FSM state encodings.
package pipe_ctrl_pkg;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Bit k stops stage k: [0]=PC, [1]=if_id, [2]=id_exe, [3]=exe_mem, [4]=mem_wb, [5]=WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EXC  = 6'b001111;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000A;
    localparam logic [31:0] EXC_OV      = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Priority encoder from per-stage stall requests to the 6-bit stall vector;
// the latest requesting stage wins because it also freezes everything before it.
module stall_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       i_req_if,
    input  logic       i_req_id,
    input  logic       i_req_ex,
    input  logic       i_req_mem,
    output logic [5:0] o_stall
);

    always_comb begin
        o_stall = STALL_NONE;
        if (i_req_mem) begin
            o_stall = STALL_MEM;
        end else if (i_req_ex) begin
            o_stall = STALL_EX;
        end else if (i_req_id) begin
            o_stall = STALL_ID;
        end else if (i_req_if) begin
            o_stall = STALL_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, exception-entry FSM (RUN/FLUSH),
// registered flush/redirect. Optional stall watchdog under PIPE_CTRL_WDOG_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [15:0] WDOG_LIMIT = 16'd1023
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stallreq_if,
    input  logic        i_stallreq_id,
    input  logic        i_stallreq_ex,
    input  logic        i_stallreq_mem,
    input  logic [31:0] i_except_type,
    input  logic [31:0] i_cp0_epc,
    output logic [5:0]  o_stall,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic        o_wdog_err
);

    logic [0:0]  r_state;
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic [5:0]  w_prio_stall;
    logic        w_accept;
    logic [5:0]  w_stall;

    stall_prio_enc u_prio_enc (
        .i_req_if  (i_stallreq_if),
        .i_req_id  (i_stallreq_id),
        .i_req_ex  (i_stallreq_ex),
        .i_req_mem (i_stallreq_mem),
        .o_stall   (w_prio_stall)
    );

    // A pending mem stall defers the exception; exe_mem is frozen so it stays stable.
    assign w_accept = (r_state == ST_RUN) && (i_except_type != ZeroWord) && !i_stallreq_mem;

    always_comb begin
        w_stall = STALL_NONE;
        if (reset || r_state == ST_FLUSH) begin
            w_stall = STALL_NONE;
        end else if (w_accept) begin
            w_stall = STALL_EXC;
        end else begin
            w_stall = w_prio_stall;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_flush  <= NoStop;
            r_new_pc <= ZeroWord;
        end else begin
            r_state <= w_accept ? ST_FLUSH : ST_RUN;
            r_flush <= w_accept;
            if (w_accept) begin
                r_new_pc <= (i_except_type == EXC_ERET) ? i_cp0_epc : EXC_VECTOR;
            end
        end
    end

    assign o_stall  = w_stall;
    assign o_flush  = r_flush;
    assign o_new_pc = r_new_pc;

`ifdef PIPE_CTRL_WDOG_EN
    logic [15:0] r_wdog_cnt;
    logic        r_wdog_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog_cnt <= 16'd0;
            r_wdog_err <= 1'b0;
        end else begin
            if (w_stall == STALL_NONE || r_flush) begin
                r_wdog_cnt <= 16'd0;
            end else if (r_wdog_cnt != 16'hFFFF) begin
                r_wdog_cnt <= r_wdog_cnt + 16'd1;
            end
            if (r_wdog_cnt == WDOG_LIMIT) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign o_wdog_err = r_wdog_err;
`else
    // Watchdog not built; the limit is folded in only to keep the parameter referenced.
    assign o_wdog_err = 1'b0 & (|WDOG_LIMIT);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl; watchdog expectations follow PIPE_CTRL_WDOG_EN.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        i_stallreq_if;
    logic        i_stallreq_id;
    logic        i_stallreq_ex;
    logic        i_stallreq_mem;
    logic [31:0] i_except_type;
    logic [31:0] i_cp0_epc;
    logic [5:0]  o_stall;
    logic        o_flush;
    logic [31:0] o_new_pc;
    logic        o_wdog_err;

`ifdef PIPE_CTRL_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [31:0] EPC  = 32'h8000_1234;
    localparam logic [3:0]  R_NO  = 4'b0000;  // {mem, ex, id, if}
    localparam logic [3:0]  R_IF  = 4'b0001;
    localparam logic [3:0]  R_ID  = 4'b0010;
    localparam logic [3:0]  R_EX  = 4'b0100;
    localparam logic [3:0]  R_MEM = 4'b1000;

    // expected entry: {stall[5:0], flush, new_pc[31:0], wdog}
    logic [39:0] exp_q[$];
    int n_vec;
    int n_err;

    pipe_ctrl #(
        .EXC_VECTOR (VEC),
        .WDOG_LIMIT (16'd5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_stallreq_if  (i_stallreq_if),
        .i_stallreq_id  (i_stallreq_id),
        .i_stallreq_ex  (i_stallreq_ex),
        .i_stallreq_mem (i_stallreq_mem),
        .i_except_type  (i_except_type),
        .i_cp0_epc      (i_cp0_epc),
        .o_stall        (o_stall),
        .o_flush        (o_flush),
        .o_new_pc       (o_new_pc),
        .o_wdog_err     (o_wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, sample just before the next posedge.
    task automatic step(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc,
                        input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                        input logic e_wdog);
        logic [39:0] e;
        {i_stallreq_mem, i_stallreq_ex, i_stallreq_id, i_stallreq_if} = req;
        i_except_type = exc;
        i_cp0_epc     = epc;
        exp_q.push_back({e_stall, e_flush, e_pc, e_wdog});
        #4;
        e = exp_q.pop_front();
        check("stall",  32'(o_stall),    32'(e[39:34]));
        check("flush",  32'(o_flush),    32'(e[33]));
        check("new_pc", o_new_pc,        e[32:1]);
        check("wdog",   32'(o_wdog_err), 32'(e[0]));
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        {i_stallreq_mem, i_stallreq_ex, i_stallreq_id, i_stallreq_if} = 4'b1111;
        i_except_type = 32'hC;
        i_cp0_epc     = EPC;
        @(negedge clk);

        // second reset cycle, all requests high
        step(4'b1111, 32'hC, EPC, 6'b000000, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;

        // single and combined requests; idle gaps keep stall runs short
        step(R_NO,  32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
        step(R_IF,  32'h0, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0);
        step(R_ID,  32'h0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
        step(R_EX,  32'h0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0);
        step(R_NO,  32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
        step(R_MEM, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0);
        step(R_MEM | R_EX | R_IF, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0);
        step(R_ID | R_IF, 32'h0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
        step(R_NO,  32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

        // overflow exception, mem idle
        step(R_NO,  32'hC, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0);
        step(R_NO,  32'h0, 32'h0, 6'b000000, 1'b1, VEC,   1'b0);
        step(R_NO,  32'h0, 32'h0, 6'b000000, 1'b0, VEC,   1'b0);

        // ERET deferred by a mem stall for 3 cycles
        for (int i = 0; i < 3; i++)
            step(R_MEM, 32'hE, EPC, 6'b011111, 1'b0, VEC, 1'b0);
        step(R_NO,  32'hE, EPC,   6'b001111, 1'b0, VEC, 1'b0);
        step(R_NO,  32'h0, 32'h0, 6'b000000, 1'b1, EPC, 1'b0);
        step(R_NO,  32'h0, 32'h0, 6'b000000, 1'b0, EPC, 1'b0);

        // exception held across FLUSH; requests ignored during FLUSH
        step(R_EX,         32'h8, 32'h0, 6'b001111, 1'b0, EPC, 1'b0);
        step(R_EX | R_MEM, 32'h8, 32'h0, 6'b000000, 1'b1, VEC, 1'b0);
        step(R_EX,         32'h8, 32'h0, 6'b001111, 1'b0, VEC, 1'b0);
        step(R_NO,         32'h0, 32'h0, 6'b000000, 1'b1, VEC, 1'b0);
        step(R_NO,         32'h0, 32'h0, 6'b000000, 1'b0, VEC, 1'b0);

        // ERET accept, then reset during FLUSH
        step(R_NO, 32'hE, 32'hCAFE_0000, 6'b001111, 1'b0, VEC, 1'b0);
        reset = 1'b1;
        step(R_EX, 32'h0, 32'h0, 6'b000000, 1'b1, 32'hCAFE_0000, 1'b0);
        reset = 1'b0;
        step(R_NO, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

        // watchdog: limit 5, error visible from the 7th stalled cycle
        for (int j = 1; j <= 9; j++)
            step(R_EX, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0, WDOG_ON && (j >= 7));
        step(R_NO, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, WDOG_ON);
        step(R_NO, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, WDOG_ON);
        reset = 1'b1;
        step(R_NO, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, WDOG_ON);
        reset = 1'b0;
        step(R_NO, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit that produces the 6-bit stall vector consumed by every inter-stage register (PC, if_id, id_exe, exe_mem, mem_wb, WB). It also produces the registered flush pulse and redirect PC used on exceptions and ERET. It arbitrates per-stage stall requests and sequences exception entry through a small FSM. It is the driver side of the stall/flush interface that the pipeline registers receive.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception entry address driven on o_new_pc for all non-ERET exceptions.
WDOG_LIMIT, 16'd1023, consecutive stalled cycles tolerated before the watchdog error (optional feature only).

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  synchronous, active-high reset.
i_stallreq_if  input  1  fetch stage requests stall (instruction bus busy).
i_stallreq_id  input  1  decode stage requests stall (load-use hazard).
i_stallreq_ex  input  1  execute stage requests stall (multi-cycle mult/div).
i_stallreq_mem  input  1  memory stage requests stall (data bus busy).
i_except_type  input  32  exception code from the MEM stage; 0 means none.
i_cp0_epc  input  32  current CP0 EPC (post-forwarding).
o_stall  output  6  [0]=PC, [1]=if_id, [2]=id_exe, [3]=exe_mem, [4]=mem_wb, [5]=WB; 1=Stop.
o_flush  output  1  one-cycle pulse; all pipeline registers clear.
o_new_pc  output  32  redirect target; valid while o_flush=1.
o_wdog_err  output  1  sticky watchdog flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset: state=RUN; o_flush=0; o_new_pc=0; o_wdog_err=0; watchdog counter=0. o_stall is combinational and evaluates to 6'b000000 while reset is high.
- o_stall is combinational from state and requests. o_flush and o_new_pc are registered.
- Stall encoding, RUN state with no exception accepted. Highest stage wins:
  - mem request: 6'b011111
  - else ex: 6'b001111
  - else id: 6'b000111
  - else if: 6'b000011
  - else 6'b000000
- Consumer rule: stage k inserts a bubble when stall[k]=1 and stall[k+1]=0. It holds when both are 1.
- FSM states: RUN, FLUSH.
- RUN, i_except_type!=0 and i_stallreq_mem=0 (exception accept):
  - cycle N: o_stall=6'b001111. PC..exe_mem freeze and mem_wb takes a bubble, so the excepting instruction never writes back.
  - next state FLUSH. Register o_flush=1.
  - Register o_new_pc = i_cp0_epc if i_except_type==EXC_ERET, else EXC_VECTOR.
- RUN, i_except_type!=0 and i_stallreq_mem=1: no accept. Normal mem stall vector 6'b011111 applies. The exception is re-evaluated each cycle; the input stays stable because exe_mem is frozen.
- FLUSH, exactly one cycle:
  - o_flush=1, o_stall=6'b000000.
  - All stall requests and i_except_type are ignored, since the stages are being flushed.
  - Next state RUN; o_flush returns to 0.
  - o_new_pc holds its value until the next accept.
- Back-to-back exceptions: the earliest next accept is the cycle after FLUSH, so o_flush pulses are never adjacent.
- Reset asserted in any state, including FLUSH, forces reset values on the next edge.

Optional Feature:
Macro: PIPE_CTRL_WDOG_EN.
- With the macro: a 16-bit counter increments each cycle in which o_stall!=0. It clears on any cycle with o_stall==0 or o_flush==1, and saturates at all-ones. When the counter equals WDOG_LIMIT, o_wdog_err sets on the next edge and stays set until reset.
- Without the macro: no counter is built and o_wdog_err is constant 0.

Decomposition:
- Shared package/header holds:
  - Stop/NoStop and ZeroWord constants
  - stall vector constants STALL_NONE/IF/ID/EX/MEM/EXC
  - exception codes: EXC_INT=32'h1, EXC_SYSCALL=32'h8, EXC_RI=32'hA, EXC_OV=32'hC, EXC_ERET=32'hE
  - FSM state encodings
- One natural sub-module: stall_prio_enc, a combinational 4-request-to-6-bit stall encoder. FSM, flush/new_pc registers and watchdog stay in pipe_ctrl.

Test Plan:
- Reset held 2 cycles with all requests high -> o_stall=0, o_flush=0, o_new_pc=0, o_wdog_err=0.
- Requests one-hot if/id/ex/mem, then if+ex+mem together -> o_stall=000011/000111/001111/011111, then 011111.
- i_except_type=32'hC in RUN, mem idle -> cycle N o_stall=001111; N+1 o_flush=1, o_new_pc=32'hBFC00380, o_stall=0; N+2 o_flush=0.
- i_except_type=32'hE, i_cp0_epc=32'h80001234, i_stallreq_mem high 3 cycles -> o_stall=011111 for 3 cycles, no flush; then accept, and o_flush pulses with o_new_pc=32'h80001234.
- Exception held high across FLUSH with i_stallreq_ex=1 -> FLUSH cycle o_stall=0; next cycle re-accept gives o_stall=001111; second o_flush pulse exactly 2 cycles after the first.
- PIPE_CTRL_WDOG_EN, WDOG_LIMIT=5, i_stallreq_ex held -> o_wdog_err rises after the 6th stalled edge and stays 1 after the request drops; reset clears it.
